dot_prod_loader: RTL and testbench
==================================

# dot_prod_loader

Serial-to-parallel front end for `dot_prod`. Accepts one complex sample pair (x, y) per handshake on a valid/ready stream and packs LENGTH consecutive samples into the packed `xi`/`xq`/`yi`/`yq` vectors that `dot_prod` consumes. Presents each completed window with `m_axis_tvalid`/`m_axis_tready`. Sits between the sample source (decimator/correlator buffer) and `dot_prod`, replacing bench-side packing in hardware.

## Interface
- `XI_BITS`, default 8: width of xi lane.
- `XQ_BITS`, default 8: width of xq lane.
- `YI_BITS`, default 8: width of yi lane.
- `YQ_BITS`, default 8: width of yq lane.
- `LENGTH`, default 4: samples per window, ≥2.
- `SLIDING`, default 0: 0 = block windows (one output per LENGTH inputs); 1 = sliding window (one output per input once full).

One clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard partial window.
- `s_axis_tvalid` in 1: input sample valid.
- `s_axis_tready` out 1: loader can accept.
- `xi_in` in XI_BITS: signed sample; `xq_in` XQ_BITS; `yi_in` YI_BITS; `yq_in` YQ_BITS.
- `m_axis_tvalid` out 1: packed window valid.
- `m_axis_tready` in 1: `dot_prod` accepts window.
- `xi` out XI_BITS*LENGTH; `xq` out XQ_BITS*LENGTH; `yi` out YI_BITS*LENGTH; `yq` out YQ_BITS*LENGTH: packed window.

## Operation
- Packing: per lane, `shreg <= (shreg << BITS) | (sample & mask)`; newest sample in LSB slot 0, oldest in slot LENGTH-1. Sample masked to lane width, never sign-extended into neighbouring slots.
- `cnt` (0..LENGTH) tracks samples in the current window.
- Accept = `s_axis_tvalid && s_axis_tready`.
- `out_free = !m_axis_tvalid || m_axis_tready`.
- Window completes on an accept when: block mode, `cnt == LENGTH-1` (then `cnt <= 0`); sliding mode, `cnt >= LENGTH-1` (`cnt` saturates at LENGTH).
- `s_axis_tready = !rst && (out_free || !completes_if_accepted)`; combinational from `m_axis_tready` and `cnt`.
- On completion: output regs load the post-shift shreg value, `m_axis_tvalid <= 1`. Otherwise `m_axis_tready` clears `m_axis_tvalid`.
- Output regs stable while `m_axis_tvalid && !m_axis_tready`.
- `flush`: `cnt <= 0`, shreg cleared. Simultaneous accept: that sample becomes slot 0 of the new window, `cnt <= 1`; no completion that cycle. Output regs and `m_axis_tvalid` unaffected by flush.

## Timing
- Reset values: `m_axis_tvalid` 0, `xi`/`xq`/`yi`/`yq` 0, `s_axis_tready` 0 during reset, `cnt` 0, shreg 0.
- Latency: last sample accepted at edge k → `m_axis_tvalid` high after edge k, 1 cycle.
- Throughput: 1 sample/cycle when `m_axis_tready` held high; sliding mode then emits 1 window/cycle after LENGTH-1 fill samples.
- Output held and completing accept simultaneously with `m_axis_tready` = 1: old window consumed and new loaded on the same edge, `m_axis_tvalid` stays 1.
- Reset mid-window or mid-hold: partial window and pending output discarded, next window starts from empty.

## Structure
- `dot_prod_pkg`: lane-width defaults, `packed_width(bits, length)` function, shared with `dot_prod` and its bench.
- Sub-module `sample_shift_lane` (params BITS, LENGTH): one masked shift register plus output register, instantiated 4×. Count, handshake and completion logic live in `dot_prod_loader`.

## Test plan
- Block, LENGTH=4, 8-bit lanes, inputs xi=1,2,3,4, `m_axis_tready`=1 → one `m_axis_tvalid` pulse, `xi`=0x01020304, one cycle after the 4th accept.
- Negative masking: xi_in=-1,0,0,0 → `xi`=0xFF000000, not 0xFFFFFFFF.
- Backpressure: `m_axis_tready`=0 after window 1, feed 4 more samples → `s_axis_tready` drops at the 4th (cnt=3), `xi` holds 0x01020304; release → window 2 loads on the same edge.
- Sliding, inputs 1..6, ready=1 → windows 0x01020304, 0x02030405, 0x03040506 on consecutive cycles.
- Flush after 2 samples together with a valid sample 9, then 7,8,6 → window `xi`=0x09070806.
- Reset asserted with `m_axis_tvalid`=1 and cnt=2 → all outputs 0 next cycle; 4 new samples produce a correct window.

Source files
------------

// File: rtl/dot_prod_pkg.sv
// ---------------------------------------------------------------------------
// dot_prod_pkg
// Shared definitions for dot_prod, its serial loader and their benches.
// Holds the default lane widths and window length, plus a helper that gives
// the width of a packed window vector (lane width times samples per window).
// No ports: this is a package.
// ---------------------------------------------------------------------------
package dot_prod_pkg;

    // Default lane widths for the four sample lanes (x/y, in-phase/quadrature)
    localparam int XI_BITS_DEF = 8;
    localparam int XQ_BITS_DEF = 8;
    localparam int YI_BITS_DEF = 8;
    localparam int YQ_BITS_DEF = 8;

    // Default number of samples packed into one window
    localparam int LENGTH_DEF  = 4;

    // Width of a packed window: one BITS-wide slot per sample
    function automatic int packed_width(input int bits, input int length);
        return bits * length;
    endfunction

endpackage

// File: rtl/sample_shift_lane.sv
// ---------------------------------------------------------------------------
// sample_shift_lane
// One lane of the window loader: a shift register that packs consecutive
// samples (newest in slot 0 at the LSB end, oldest in slot LENGTH-1) and an
// output register that captures the freshly shifted window on completion.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset, clears both registers
//   i_flush   in   discard the partial window held in the shift register
//   i_accept  in   a sample is being accepted this cycle
//   i_load    in   this accept completes a window; capture it to the output
//   i_sample  in   BITS-wide sample, shifted in without sign extension
//   o_window  out  BITS*LENGTH packed window, held until the next load
// ---------------------------------------------------------------------------
module sample_shift_lane
    import dot_prod_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int LENGTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_flush,
    input  logic                                   i_accept,
    input  logic                                   i_load,
    input  logic [BITS-1:0]                        i_sample,
    output logic [packed_width(BITS, LENGTH)-1:0]  o_window
);

    localparam int W = packed_width(BITS, LENGTH);

    logic [W-1:0] r_shreg;
    logic [W-1:0] r_window;
    logic [W-1:0] w_shifted;
    logic [W-1:0] w_fresh;

    // The incoming sample is concatenated rather than OR-ed after a
    // sign-extending cast, so a negative sample can never spill ones into the
    // older slots. The oldest slot simply falls off the top.
    assign w_shifted = {r_shreg[W-BITS-1:0], i_sample};

    // A flush that coincides with an accept starts a new window holding only
    // the accepted sample in slot 0.
    assign w_fresh = {{(W-BITS){1'b0}}, i_sample};

    // Shift register and output register. The output register only moves on
    // a completing accept, so it stays stable while the consumer stalls. A
    // flush never touches the output register; completion logic upstream
    // guarantees i_load is low whenever i_flush is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_window <= '0;
        end else begin
            if (i_flush) begin
                r_shreg <= i_accept ? w_fresh : '0;
            end else if (i_accept) begin
                r_shreg <= w_shifted;
            end
            if (i_load) begin
                r_window <= w_shifted;
            end
        end
    end

    assign o_window = r_window;

endmodule

// File: rtl/dot_prod_loader.sv
// ---------------------------------------------------------------------------
// dot_prod_loader
// Serial-to-parallel front end for dot_prod. Accepts one complex sample pair
// (x, y) per valid/ready handshake and packs LENGTH consecutive samples into
// the packed xi/xq/yi/yq vectors, presenting each completed window on a
// valid/ready output. SLIDING=0 emits one window per LENGTH inputs;
// SLIDING=1 emits one window per input once the window has filled.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   flush          in   discard the partial window
//   s_axis_tvalid  in   input sample valid
//   s_axis_tready  out  loader can accept (combinational, low in reset)
//   xi_in/xq_in/yi_in/yq_in   in   signed lane samples
//   m_axis_tvalid  out  packed window valid
//   m_axis_tready  in   consumer accepts the window
//   xi/xq/yi/yq    out  packed windows, newest sample in the LSB slot
// ---------------------------------------------------------------------------
module dot_prod_loader
    import dot_prod_pkg::*;
#(
    parameter int XI_BITS = XI_BITS_DEF,
    parameter int XQ_BITS = XQ_BITS_DEF,
    parameter int YI_BITS = YI_BITS_DEF,
    parameter int YQ_BITS = YQ_BITS_DEF,
    parameter int LENGTH  = LENGTH_DEF,
    parameter int SLIDING = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [XI_BITS-1:0]                        xi_in,
    input  logic [XQ_BITS-1:0]                        xq_in,
    input  logic [YI_BITS-1:0]                        yi_in,
    input  logic [YQ_BITS-1:0]                        yq_in,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [packed_width(XI_BITS, LENGTH)-1:0]  xi,
    output logic [packed_width(XQ_BITS, LENGTH)-1:0]  xq,
    output logic [packed_width(YI_BITS, LENGTH)-1:0]  yi,
    output logic [packed_width(YQ_BITS, LENGTH)-1:0]  yq
);

    localparam int               CW       = $clog2(LENGTH + 1);
    localparam logic [CW-1:0]    CNT_ZERO = '0;
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(LENGTH - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(LENGTH);

    logic [CW-1:0] r_cnt;
    logic          r_mValid;
    logic          w_outFree;
    logic          w_completesIfAccepted;
    logic          w_sReady;
    logic          w_accept;
    logic          w_load;

    // The output slot is free when nothing is pending or the pending window
    // is being consumed on this very edge.
    assign w_outFree = !r_mValid || m_axis_tready;

    // Would the next accept finish a window? Block mode finishes exactly on
    // the LENGTH-th sample; sliding mode finishes on every sample from the
    // LENGTH-th onward. A flush restarts the window, so nothing completes in
    // a flush cycle.
    always_comb begin
        w_completesIfAccepted = 1'b0;
        if (!flush) begin
            if (SLIDING != 0) begin
                w_completesIfAccepted = (r_cnt >= CNT_LAST);
            end else begin
                w_completesIfAccepted = (r_cnt == CNT_LAST);
            end
        end
    end

    // Only stall the source when its sample would complete a window that has
    // nowhere to go; partial-window samples are always taken.
    assign w_sReady = !rst && (w_outFree || !w_completesIfAccepted);
    assign w_accept = s_axis_tvalid && w_sReady;
    assign w_load   = w_accept && w_completesIfAccepted;

    // Sample count for the current window. Block mode wraps to zero on
    // completion; sliding mode saturates at LENGTH so every later sample
    // completes a window. A flush with an accept leaves one sample in hand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
        end else if (flush) begin
            r_cnt <= w_accept ? CNT_ONE : CNT_ZERO;
        end else if (w_accept) begin
            if (SLIDING != 0) begin
                if (r_cnt != CNT_FULL) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= w_completesIfAccepted ? CNT_ZERO : r_cnt + CNT_ONE;
            end
        end
    end

    // Output valid. A completing accept wins over consumption so that a
    // window consumed and a new one loaded on the same edge keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mValid <= 1'b0;
        end else if (w_load) begin
            r_mValid <= 1'b1;
        end else if (m_axis_tready) begin
            r_mValid <= 1'b0;
        end
    end

    assign s_axis_tready = w_sReady;
    assign m_axis_tvalid = r_mValid;

    sample_shift_lane #(.BITS(XI_BITS), .LENGTH(LENGTH)) u_laneXi (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_accept (w_accept),
        .i_load   (w_load),
        .i_sample (xi_in),
        .o_window (xi)
    );

    sample_shift_lane #(.BITS(XQ_BITS), .LENGTH(LENGTH)) u_laneXq (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_accept (w_accept),
        .i_load   (w_load),
        .i_sample (xq_in),
        .o_window (xq)
    );

    sample_shift_lane #(.BITS(YI_BITS), .LENGTH(LENGTH)) u_laneYi (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_accept (w_accept),
        .i_load   (w_load),
        .i_sample (yi_in),
        .o_window (yi)
    );

    sample_shift_lane #(.BITS(YQ_BITS), .LENGTH(LENGTH)) u_laneYq (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_accept (w_accept),
        .i_load   (w_load),
        .i_sample (yq_in),
        .o_window (yq)
    );

endmodule

// File: tb/tb_dot_prod_loader.sv
// ---------------------------------------------------------------------------
// tb_dot_prod_loader
// Directed bench for dot_prod_loader. Two instances share clock, reset,
// flush, sample data and m_axis_tready: dutA in block mode, dutB in sliding
// mode, each with its own s_axis_tvalid. Expected windows are hand-computed.
// ---------------------------------------------------------------------------
module tb_dot_prod_loader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        vldA;
    logic        vldB;
    logic        rdyA;
    logic        rdyB;
    logic [7:0]  xiIn;
    logic [7:0]  xqIn;
    logic [7:0]  yiIn;
    logic [7:0]  yqIn;
    logic        mReady;
    logic        mValidA;
    logic        mValidB;
    logic [31:0] xiA, xqA, yiA, yqA;
    logic [31:0] xiB, xqB, yiB, yqB;

    int nCompared;
    int nMismatched;

    dot_prod_loader #(.LENGTH(4), .SLIDING(0)) dutA (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tvalid (vldA),
        .s_axis_tready (rdyA),
        .xi_in         (xiIn),
        .xq_in         (xqIn),
        .yi_in         (yiIn),
        .yq_in         (yqIn),
        .m_axis_tvalid (mValidA),
        .m_axis_tready (mReady),
        .xi            (xiA),
        .xq            (xqA),
        .yi            (yiA),
        .yq            (yqA)
    );

    dot_prod_loader #(.LENGTH(4), .SLIDING(1)) dutB (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .s_axis_tvalid (vldB),
        .s_axis_tready (rdyB),
        .xi_in         (xiIn),
        .xq_in         (xqIn),
        .yi_in         (yiIn),
        .yq_in         (yqIn),
        .m_axis_tvalid (mValidB),
        .m_axis_tready (mReady),
        .xi            (xiB),
        .xq            (xqB),
        .yi            (yiB),
        .yq            (yqB)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one sample to the chosen DUT for exactly one clock edge, then
    // leave the bench 1 unit after that edge with valid low.
    task automatic send(input bit toB, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        xiIn = a;
        xqIn = b;
        yiIn = c;
        yqIn = d;
        vldA = !toB;
        vldB = toB;
        @(posedge clk);
        #1;
        vldA = 1'b0;
        vldB = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_mvalid: got %b want 0", mValidA);
        end
        nCompared++;
        if ({xiA, xqA, yiA, yqA} !== 128'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_windows: got %h want 0", {xiA, xqA, yiA, yqA});
        end
        nCompared++;
        if (rdyA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_sready: got %b want 0", rdyA);
        end
        rst = 1'b0;
        #1;
        nCompared++;
        if (rdyA !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_sready: got %b want 1", rdyA);
        end
    endtask

    task automatic test_block();
        mReady = 1'b1;
        send(0, 8'h01, 8'h11, 8'hA0, 8'hFF);
        send(0, 8'h02, 8'h22, 8'hA1, 8'hFE);
        send(0, 8'h03, 8'h33, 8'hA2, 8'hFD);
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL block_early_valid: got %b want 0", mValidA);
        end
        send(0, 8'h04, 8'h44, 8'hA3, 8'hFC);
        nCompared++;
        if (mValidA !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL block_valid: got %b want 1", mValidA);
        end
        nCompared++;
        if (xiA !== 32'h01020304) begin
            nMismatched++;
            $display("[TB] FAIL block_xi: got %h want 01020304", xiA);
        end
        nCompared++;
        if (xqA !== 32'h11223344 || yiA !== 32'hA0A1A2A3 || yqA !== 32'hFFFEFDFC) begin
            nMismatched++;
            $display("[TB] FAIL block_other_lanes: got %h %h %h want 11223344 a0a1a2a3 fffefdfc",
                     xqA, yiA, yqA);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL block_pulse_end: got %b want 0", mValidA);
        end
    endtask

    task automatic test_negative_mask();
        mReady = 1'b1;
        send(0, 8'hFF, 8'h00, 8'h00, 8'h00);
        send(0, 8'h00, 8'h00, 8'h00, 8'h00);
        send(0, 8'h00, 8'h00, 8'h00, 8'h00);
        send(0, 8'h00, 8'h00, 8'h00, 8'h80);
        nCompared++;
        if (mValidA !== 1'b1 || xiA !== 32'hFF000000) begin
            nMismatched++;
            $display("[TB] FAIL neg_mask_xi: got v=%b %h want v=1 ff000000", mValidA, xiA);
        end
        nCompared++;
        if (yqA !== 32'h00000080) begin
            nMismatched++;
            $display("[TB] FAIL neg_mask_yq: got %h want 00000080", yqA);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        mReady = 1'b0;
        send(0, 8'h01, 8'h00, 8'h00, 8'h00);
        send(0, 8'h02, 8'h00, 8'h00, 8'h00);
        send(0, 8'h03, 8'h00, 8'h00, 8'h00);
        send(0, 8'h04, 8'h00, 8'h00, 8'h00);
        send(0, 8'h05, 8'h00, 8'h00, 8'h00);
        send(0, 8'h06, 8'h00, 8'h00, 8'h00);
        send(0, 8'h07, 8'h00, 8'h00, 8'h00);
        nCompared++;
        if (rdyA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_sready_drop: got %b want 0", rdyA);
        end
        xiIn = 8'h08;
        vldA = 1'b1;
        @(posedge clk);
        #1;
        nCompared++;
        if (mValidA !== 1'b1 || xiA !== 32'h01020304) begin
            nMismatched++;
            $display("[TB] FAIL bp_hold: got v=%b %h want v=1 01020304", mValidA, xiA);
        end
        mReady = 1'b1;
        #1;
        nCompared++;
        if (rdyA !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL bp_sready_release: got %b want 1", rdyA);
        end
        @(posedge clk);
        #1;
        vldA = 1'b0;
        nCompared++;
        if (mValidA !== 1'b1 || xiA !== 32'h05060708) begin
            nMismatched++;
            $display("[TB] FAIL bp_window2: got v=%b %h want v=1 05060708", mValidA, xiA);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_drain: got %b want 0", mValidA);
        end
    endtask

    task automatic test_sliding();
        logic [31:0] expXi [3];
        expXi[0] = 32'h01020304;
        expXi[1] = 32'h02030405;
        expXi[2] = 32'h03040506;
        mReady = 1'b1;
        send(1, 8'h01, 8'h00, 8'h00, 8'hF1);
        send(1, 8'h02, 8'h00, 8'h00, 8'hF2);
        send(1, 8'h03, 8'h00, 8'h00, 8'hF3);
        nCompared++;
        if (mValidB !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL slide_fill_valid: got %b want 0", mValidB);
        end
        for (int k = 0; k < 3; k++) begin
            send(1, 8'(k + 4), 8'h00, 8'h00, 8'(8'hF4 + k));
            nCompared++;
            if (mValidB !== 1'b1 || xiB !== expXi[k]) begin
                nMismatched++;
                $display("[TB] FAIL slide_window%0d: got v=%b %h want v=1 %h",
                         k, mValidB, xiB, expXi[k]);
            end
        end
        nCompared++;
        if (yqB !== 32'hF3F4F5F6) begin
            nMismatched++;
            $display("[TB] FAIL slide_yq: got %h want f3f4f5f6", yqB);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (mValidB !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL slide_idle: got %b want 0", mValidB);
        end
    endtask

    task automatic test_flush();
        mReady = 1'b1;
        send(0, 8'h01, 8'h00, 8'h00, 8'h00);
        send(0, 8'h02, 8'h00, 8'h00, 8'h00);
        flush = 1'b1;
        send(0, 8'h09, 8'h00, 8'h00, 8'h00);
        flush = 1'b0;
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL flush_no_complete: got %b want 0", mValidA);
        end
        send(0, 8'h07, 8'h00, 8'h00, 8'h00);
        send(0, 8'h08, 8'h00, 8'h00, 8'h00);
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL flush_partial: got %b want 0", mValidA);
        end
        send(0, 8'h06, 8'h00, 8'h00, 8'h00);
        nCompared++;
        if (mValidA !== 1'b1 || xiA !== 32'h09070806) begin
            nMismatched++;
            $display("[TB] FAIL flush_window: got v=%b %h want v=1 09070806", mValidA, xiA);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midwindow();
        mReady = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            send(0, 8'(k), 8'h00, 8'h00, 8'h00);
        end
        nCompared++;
        if (mValidA !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid_setup: got %b want 1", mValidA);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        nCompared++;
        if (mValidA !== 1'b0 || xiA !== 32'h0 || rdyA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid_clear: got v=%b xi=%h rdy=%b want v=0 xi=0 rdy=0",
                     mValidA, xiA, rdyA);
        end
        rst = 1'b0;
        mReady = 1'b1;
        send(0, 8'h0A, 8'h00, 8'h00, 8'h00);
        send(0, 8'h0B, 8'h00, 8'h00, 8'h00);
        send(0, 8'h0C, 8'h00, 8'h00, 8'h00);
        nCompared++;
        if (mValidA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid_refill: got %b want 0", mValidA);
        end
        send(0, 8'h0D, 8'h00, 8'h00, 8'h00);
        nCompared++;
        if (mValidA !== 1'b1 || xiA !== 32'h0A0B0C0D) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid_window: got v=%b %h want v=1 0a0b0c0d", mValidA, xiA);
        end
    endtask

    // Scenario sequence; each task leaves the bench 1 unit after an edge
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        vldA   = 1'b0;
        vldB   = 1'b0;
        mReady = 1'b0;
        xiIn   = '0;
        xqIn   = '0;
        yiIn   = '0;
        yqIn   = '0;
        test_reset();
        test_block();
        test_negative_mask();
        test_backpressure();
        test_sliding();
        test_flush();
        test_reset_midwindow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
